// File: rtl/sync_ctr_pkg.sv
// Shared constants and state type for the lab's synchronous counters.
// The state type is used only when SYNC_DOWN_ONESHOT_EN is defined.
package sync_ctr_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_MOD   = 16;

    typedef enum logic {
        COUNT = 1'b0,
        HALT  = 1'b1
    } state_t;

endpackage

// File: rtl/dff_arl.sv
// Single-bit D flip-flop with async active-low clear to a selectable
// preset value; provides true and complement outputs.
module dff_arl #(
    parameter logic PRE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= PRE;
        else      q <= d;
    end

    assign qb = ~q;

endmodule

// File: rtl/sync_down.sv
// Modulo-MOD synchronous down counter with load, enable, tc and wrap.
// Define SYNC_DOWN_ONESHOT_EN to halt at zero instead of wrapping.
module sync_down
    import sync_ctr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] nq;
    logic             nwrap;
    logic             zero;
    logic             wrap_unused;
    logic [WIDTH-1:0] ld_val;

    assign zero   = &qn;
    assign ld_val = ({1'b0, d} >= MODW) ? TOP : d;

    // Reset value MOD-1 comes from per-bit preset selection.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_arl #(.PRE(TOP[i])) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (nq[i]),
            .q   (q[i]),
            .qb  (qn[i])
        );
    end

    dff_arl #(.PRE(1'b0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .d   (nwrap),
        .q   (wrap),
        .qb  (wrap_unused)
    );

`ifdef SYNC_DOWN_ONESHOT_EN
    state_t state;
    state_t nstate;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= COUNT;
        else      state <= nstate;
    end

    always_comb begin
        nq     = q;
        nwrap  = 1'b0;
        nstate = state;
        if (load) begin
            nq     = ld_val;
            nstate = COUNT;
        end else if (state == COUNT && en) begin
            if (!zero) begin
                nq = q - WIDTH'(1);
            end else begin
                nwrap  = 1'b1;
                nstate = HALT;
            end
        end
    end

    assign tc = en & zero & (state == COUNT);
`else
    always_comb begin
        nq    = q;
        nwrap = 1'b0;
        if (load) begin
            nq = ld_val;
        end else if (en) begin
            if (!zero) begin
                nq = q - WIDTH'(1);
            end else begin
                nq    = TOP;
                nwrap = 1'b1;
            end
        end
    end

    assign tc = en & zero;
`endif

endmodule

// File: tb/tb_sync_down.sv
// Directed self-checking bench for sync_down (MOD=16, MOD=10, cascade).
// One-shot scenario replaces the wrap scenarios when SYNC_DOWN_ONESHOT_EN is set.
module tb_sync_down;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       en_a = 1'b0, load_a = 1'b0;
    logic [3:0] d_a = '0, q_a;
    logic       tc_a, wrap_a;

    logic       en_b = 1'b0, load_b = 1'b0;
    logic [3:0] d_b = '0, q_b;
    logic       tc_b, wrap_b;

    logic       en_c = 1'b0, load_c = 1'b0;
    logic [7:0] d_c = '0;
    logic [3:0] q_c0, q_c1;
    logic       tc_c0, tc_c1, wrap_c0, wrap_c1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_down #(.WIDTH(4), .MOD(16)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .load(load_a), .d(d_a),
        .q(q_a), .tc(tc_a), .wrap(wrap_a)
    );

    sync_down #(.WIDTH(4), .MOD(10)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .load(load_b), .d(d_b),
        .q(q_b), .tc(tc_b), .wrap(wrap_b)
    );

    sync_down #(.WIDTH(4), .MOD(16)) u_c0 (
        .clk(clk), .rst(rst), .en(en_c), .load(load_c), .d(d_c[3:0]),
        .q(q_c0), .tc(tc_c0), .wrap(wrap_c0)
    );

    sync_down #(.WIDTH(4), .MOD(16)) u_c1 (
        .clk(clk), .rst(rst), .en(tc_c0), .load(load_c), .d(d_c[7:4]),
        .q(q_c1), .tc(tc_c1), .wrap(wrap_c1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        en_a = 1'b0;
        load_a = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (q_a !== 4'd15) begin
            errors++;
            $display("FAIL reset_q got %0d want 15", q_a);
        end
        checks++;
        if (wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap got %b want 0", wrap_a);
        end
        rst = 1'b1;
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        checks++;
        if (q_a !== 4'd14) begin
            errors++;
            $display("FAIL reset_first_dec got %0d want 14", q_a);
        end
    endtask

    task automatic test_full_cycle();
        logic [3:0] exp;
        logic       w;
        do_reset();
        en_a = 1'b1;
        exp = 4'd15;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (tc_a !== (exp == 4'd0)) begin
                errors++;
                $display("FAIL full_tc q=%0d got %b want %b",
                         exp, tc_a, exp == 4'd0);
            end
            step();
            w = (exp == 4'd0);
            exp = (exp == 4'd0) ? 4'd15 : exp - 4'd1;
            checks++;
            if (q_a !== exp || wrap_a !== w) begin
                errors++;
                $display("FAIL full_q step %0d got q=%0d wrap=%b want q=%0d wrap=%b",
                         i, q_a, wrap_a, exp, w);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_modulus();
        logic [3:0] exp;
        logic       w;
        load_b = 1'b1;
        d_b = 4'd12;
        step();
        load_b = 1'b0;
        checks++;
        if (q_b !== 4'd9) begin
            errors++;
            $display("FAIL mod_clamp got %0d want 9", q_b);
        end
        en_b = 1'b1;
        exp = 4'd9;
        for (int i = 0; i < 10; i++) begin
            step();
            w = (exp == 4'd0);
            exp = (exp == 4'd0) ? 4'd9 : exp - 4'd1;
            checks++;
            if (q_b !== exp || wrap_b !== w) begin
                errors++;
                $display("FAIL mod_seq step %0d got q=%0d wrap=%b want q=%0d wrap=%b",
                         i, q_b, wrap_b, exp, w);
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_priority();
        load_a = 1'b1;
        d_a = 4'd2;
        step();
        d_a = 4'd5;
        en_a = 1'b1;
        step();
        load_a = 1'b0;
        en_a = 1'b0;
        checks++;
        if (q_a !== 4'd5 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL prio_load got q=%0d wrap=%b want q=5 wrap=0",
                     q_a, wrap_a);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q_a !== 4'd5 || tc_a !== 1'b0) begin
                errors++;
                $display("FAIL prio_hold got q=%0d tc=%b want q=5 tc=0",
                         q_a, tc_a);
            end
        end
        load_a = 1'b1;
        en_a = 1'b1;
        d_a = 4'd0;
        step();
        load_a = 1'b0;
        checks++;
        if (q_a !== 4'd0 || tc_a !== 1'b1) begin
            errors++;
            $display("FAIL load_zero got q=%0d tc=%b want q=0 tc=1",
                     q_a, tc_a);
        end
        en_a = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        load_a = 1'b1;
        d_a = 4'd6;
        step();
        load_a = 1'b0;
        checks++;
        if (q_a !== 4'd6) begin
            errors++;
            $display("FAIL async_pre got %0d want 6", q_a);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (q_a !== 4'd15 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL async_clear got q=%0d wrap=%b want q=15 wrap=0",
                     q_a, wrap_a);
        end
        rst = 1'b1;
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        checks++;
        if (q_a !== 4'd14) begin
            errors++;
            $display("FAIL async_resume got %0d want 14", q_a);
        end
    endtask

    task automatic test_cascade();
        logic [7:0] exp;
        load_c = 1'b1;
        d_c = 8'h00;
        step();
        load_c = 1'b0;
        checks++;
        if ({q_c1, q_c0} !== 8'h00) begin
            errors++;
            $display("FAIL casc_load got %h want 00", {q_c1, q_c0});
        end
        en_c = 1'b1;
        exp = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            exp = exp - 8'h01;
            checks++;
            if ({q_c1, q_c0} !== exp) begin
                errors++;
                $display("FAIL casc_seq step %0d got %h want %h",
                         i, {q_c1, q_c0}, exp);
            end
        end
        en_c = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_q [6]  = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
        logic       exp_w [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        load_a = 1'b1;
        d_a = 4'd3;
        step();
        load_a = 1'b0;
        en_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            checks++;
            if (q_a !== exp_q[i] || wrap_a !== exp_w[i] || tc_a !== exp_tc[i]) begin
                errors++;
                $display("FAIL oneshot %0d got q=%0d wrap=%b tc=%b want q=%0d wrap=%b tc=%b",
                         i, q_a, wrap_a, tc_a, exp_q[i], exp_w[i], exp_tc[i]);
            end
        end
        load_a = 1'b1;
        d_a = 4'd2;
        step();
        load_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++;
            if (q_a !== 4'(2 - i)) begin
                errors++;
                $display("FAIL oneshot_reload %0d got %0d want %0d",
                         i, q_a, 2 - i);
            end
        end
        en_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_async_reset();
`ifdef SYNC_DOWN_ONESHOT_EN
        test_oneshot();
`else
        test_full_cycle();
        test_modulus();
        test_cascade();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
